// File: rtl/mc_core_hs.sv
// mc_core_hs: multicycle MIPS-subset CPU (control FSM, PC, IR, 32x32 regfile, ALU) on one shared memory port.
// Latency with zero-wait memory: J/JAL/JR 2, BNE 3, R-type/ADDI/XORI/SW 4, LW 5 cycles; each stall cycle adds one.
// Backpressure: FETCH and MEM hold mem_req/mem_addr/mem_wdata stable until mem_ready; an illegal opcode parks in HALT.
// Optional: define MC_CORE_PERF_CNT_EN to build the cycle/instret counters; otherwise both outputs read 0.
module mc_core_hs #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_dbg,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  instret_cnt
);
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B, OP_BNE  = 6'h05, OP_J    = 6'h02, OP_JAL = 6'h03;
   localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_SLT  = 6'h2A, FN_JR  = 6'h08;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t            state, state_nx;
   logic              run;          // low only in the first cycle after reset, so mem_req rises one edge later
   logic [ADDR_W-1:0] pc, addr_q;
   logic [31:0]       ir, a, b, alu_q, mdr;
   logic [31:0]       regs [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wr_idx;
   logic [31:0] sext_imm, zext_imm, rs_val, rt_val, alu_res, wr_dat;
   logic        legal, is_jump, is_mem;

   assign op       = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign funct    = ir[5:0];
   assign sext_imm = {{16{ir[15]}}, ir[15:0]};
   assign zext_imm = {16'd0, ir[15:0]};
   assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
   assign is_jump  = (op == OP_J) || (op == OP_JAL) || ((op == OP_RTYPE) && (funct == FN_JR));
   assign is_mem   = (op == OP_LW) || (op == OP_SW);
   assign wr_idx   = (op == OP_RTYPE) ? rd : rt;
   assign wr_dat   = (op == OP_LW) ? mdr : alu_q;
   assign halted   = (state == S_HALT);
   assign pc_dbg   = pc;

   // Opcode/funct legality check for the instruction held in IR
   always_comb begin
      legal = 1'b0;
      case (op)
         OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT) || (funct == FN_JR);
         OP_ADDI, OP_XORI, OP_LW, OP_SW, OP_BNE, OP_J, OP_JAL: legal = 1'b1;
         default:  legal = 1'b0;
      endcase
   end

   // ALU on the latched operands; LW/SW reuse the adder for the effective address
   always_comb begin
      alu_res = 32'd0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_res = a + b;
               FN_SUB:  alu_res = a - b;
               FN_SLT:  alu_res = {31'd0, ($signed(a) < $signed(b))};
               default: alu_res = 32'd0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: alu_res = a + sext_imm;
         OP_XORI:               alu_res = a ^ zext_imm;
         default:               alu_res = 32'd0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nx;
   end

   // Next-state and memory port drive; outputs stay constant through a stall
   always_comb begin
      state_nx  = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc;
      mem_wdata = b;
      case (state)
         S_FETCH: begin
            if (run) begin
               mem_req = 1'b1;
               if (mem_ready) state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!legal)       state_nx = S_HALT;
            else if (is_jump) state_nx = S_FETCH;
            else              state_nx = S_EXEC;
         end
         S_EXEC: begin
            if (op == OP_BNE) state_nx = S_FETCH;
            else if (is_mem)  state_nx = S_MEM;
            else              state_nx = S_WB;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = (op == OP_SW);
            mem_addr = addr_q;
            if (mem_ready) state_nx = (op == OP_SW) ? S_FETCH : S_WB;
         end
         S_WB:    state_nx = S_FETCH;
         S_HALT:  state_nx = S_HALT;
         default: state_nx = S_FETCH;
      endcase
   end

   // Datapath registers and register file, updated per state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run    <= 1'b0;
         pc     <= RESET_PC;
         addr_q <= '0;
         ir     <= 32'd0;
         a      <= 32'd0;
         b      <= 32'd0;
         alu_q  <= 32'd0;
         mdr    <= 32'd0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else begin
         run <= 1'b1;
         case (state)
            S_FETCH: begin
               if (run && mem_ready) begin
                  ir <= mem_rdata;
                  pc <= pc + ADDR_W'(1);
               end
            end
            S_DECODE: begin
               a <= rs_val;
               b <= rt_val;
               if (legal) begin
                  if (op == OP_J) pc <= ADDR_W'(ir[25:0]);
                  if (op == OP_JAL) begin
                     regs[31] <= 32'(pc);
                     pc       <= ADDR_W'(ir[25:0]);
                  end
                  if ((op == OP_RTYPE) && (funct == FN_JR)) pc <= ADDR_W'(rs_val);
               end
            end
            S_EXEC: begin
               alu_q  <= alu_res;
               addr_q <= ADDR_W'(alu_res);
               if ((op == OP_BNE) && (a != b)) pc <= pc + ADDR_W'($signed(sext_imm));
            end
            S_MEM: begin
               if (mem_ready && (op == OP_LW)) mdr <= mem_rdata;
            end
            S_WB: begin
               if (wr_idx != 5'd0) regs[wr_idx] <= wr_dat;
            end
            default: ;
         endcase
      end
   end

`ifdef MC_CORE_PERF_CNT_EN
   logic             retire;
   logic [CNT_W-1:0] cyc_q, ret_q;

   assign retire = ((state == S_DECODE) && legal && is_jump) ||
                   ((state == S_EXEC) && (op == OP_BNE)) ||
                   ((state == S_MEM) && mem_ready && (op == OP_SW)) ||
                   (state == S_WB);

   // Performance counters; cycles are counted only while the core runs outside HALT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (run && (state != S_HALT)) cyc_q <= cyc_q + CNT_W'(1);
         if (retire)                   ret_q <= ret_q + CNT_W'(1);
      end
   end

   assign cycle_cnt   = cyc_q;
   assign instret_cnt = ret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif
endmodule
